odd_even_sort: RTL and testbench

//   Parametrised, multi-cycle sorting engine for N packed elements of W bits each.

---
 rtl/odd_even_sort.sv | 149 ++++++++++++++
 tb/tb_odd_even_sort.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/odd_even_sort.sv
// odd_even_sort: multi-cycle odd-even transposition sorter for N packed
// W-bit elements. One compare/swap phase is performed per clock.
// Supports ascending/descending order, signed/unsigned compare, optional
// early exit and a busy/done handshake.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   start     : begin a sort; only looked at in IDLE
//   desc      : 0 ascending, 1 descending; captured with start
//   data_in   : element i = data_in[i*W +: W]; captured with start
//   data_out  : last sorted result, element 0 first in sort order
//   busy      : high while phases are running
//   done      : one-cycle pulse once data_out holds the new result

// Compare/swap cell for one adjacent pair (lo, hi).
module odd_even_sort_cas #(
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input  logic         en,
  input  logic         desc,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic         swap
);
  // Flipping the MSB turns a two's-complement compare into an unsigned one.
  localparam logic [W-1:0] FLIP = (SIGNED != 0) ? (W'(1) << (W-1)) : '0;

  logic [W-1:0] lo_k, hi_k;
  assign lo_k = lo ^ FLIP;
  assign hi_k = hi ^ FLIP;
  // Strict compares: equal elements stay put, keeping the sort stable.
  assign swap = en & (desc ? (lo_k < hi_k) : (lo_k > hi_k));
endmodule

module odd_even_sort #(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int SIGNED     = 0,
  parameter int EARLY_EXIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           desc,
  input  logic [N*W-1:0] data_in,
  output logic [N*W-1:0] data_out,
  output logic           busy,
  output logic           done
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t              state_q, state_d;
  logic [N-1:0][W-1:0] arr_q, arr_d, arr_nxt;
  logic [N-1:0][W-1:0] out_q, out_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                desc_q, desc_d;
  logic                clean_q, clean_d;   // previous phase made no swaps
  logic [N-2:0]        swp;
  logic                any_swap, exit_now;

  // Pair (i, i+1) is active when its low index parity matches the phase parity.
  for (genvar i = 0; i < N-1; i++) begin : g_cas
    localparam logic PAR = logic'(i % 2);
    odd_even_sort_cas #(.W(W), .SIGNED(SIGNED)) u_cas (
      .en   (cnt_q[0] == PAR),
      .desc (desc_q),
      .lo   (arr_q[i]),
      .hi   (arr_q[i+1]),
      .swap (swp[i])
    );
  end

  // Active pairs are disjoint, so each element takes at most one neighbour.
  for (genvar j = 0; j < N; j++) begin : g_net
    if (j == 0) begin : g_first
      assign arr_nxt[j] = swp[j] ? arr_q[j+1] : arr_q[j];
    end else if (j == N-1) begin : g_last
      assign arr_nxt[j] = swp[j-1] ? arr_q[j-1] : arr_q[j];
    end else begin : g_mid
      assign arr_nxt[j] = swp[j]   ? arr_q[j+1] :
                          swp[j-1] ? arr_q[j-1] : arr_q[j];
    end
  end

  assign any_swap = |swp;
  assign exit_now = (cnt_q == CW'(N-1)) ||
                    ((EARLY_EXIT != 0) && (cnt_q != '0) && !any_swap && clean_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = SORT;
      SORT:    if (exit_now) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy     = (state_q == SORT);
    done     = (state_q == DONE);
    data_out = out_q;
  end

  // Datapath next values
  always_comb begin
    arr_d   = arr_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    desc_d  = desc_q;
    clean_d = clean_q;
    if (state_q == IDLE && start) begin
      arr_d   = data_in;
      desc_d  = desc;
      cnt_d   = '0;
      clean_d = 1'b0;
    end else if (state_q == SORT) begin
      arr_d   = arr_nxt;
      cnt_d   = cnt_q + 1'b1;
      clean_d = !any_swap;
      if (exit_now) out_d = arr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      desc_q  <= 1'b0;
      clean_q <= 1'b0;
    end else begin
      arr_q   <= arr_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      desc_q  <= desc_d;
      clean_q <= clean_d;
    end
  end
endmodule

// File: tb/tb_odd_even_sort.sv
module tb_odd_even_sort;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: default, 1: SIGNED=1, 2: EARLY_EXIT=0, 3: N=2
  logic [3:0]        start_v, desc_v;
  logic [3:0][31:0]  din_v;
  logic [3:0][31:0]  dout_v;
  logic [3:0]        busy_v, done_v;
  logic [15:0]       dout3;
  assign dout_v[3] = {16'h0, dout3};

  odd_even_sort u_def (.clk(clk), .rst(rst), .start(start_v[0]), .desc(desc_v[0]),
    .data_in(din_v[0]), .data_out(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  odd_even_sort #(.SIGNED(1)) u_sgn (.clk(clk), .rst(rst), .start(start_v[1]), .desc(desc_v[1]),
    .data_in(din_v[1]), .data_out(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  odd_even_sort #(.EARLY_EXIT(0)) u_nee (.clk(clk), .rst(rst), .start(start_v[2]), .desc(desc_v[2]),
    .data_in(din_v[2]), .data_out(dout_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  odd_even_sort #(.N(2)) u_n2 (.clk(clk), .rst(rst), .start(start_v[3]), .desc(desc_v[3]),
    .data_in(din_v[3][15:0]), .data_out(dout3), .busy(busy_v[3]), .done(done_v[3]));

  typedef struct {
    int          sel;
    logic [31:0] din;
    logic        desc;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last [4];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the edge where done has dropped.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   lat;
    start_v[v.sel] = 1'b1;
    desc_v[v.sel]  = v.desc;
    din_v[v.sel]   = v.din;
    sb_q.push_back('{v.exp, v.lat});
    @(posedge clk); #1;                         // E0
    start_v[v.sel] = 1'b0;
    din_v[v.sel]   = $urandom;                  // must not disturb the running sort
    desc_v[v.sel]  = ~v.desc;
    chk("busy_after_start", {31'b0, busy_v[v.sel]}, 32'd1);
    chk("dout_held_mid_sort", dout_v[v.sel], last[v.sel]);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done_v[v.sel]) begin lat = k; break; end
    end
    e = sb_q.pop_front();
    if (lat == 0) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: inst %0d got no done, expected one within 20 cycles", v.sel);
    end else begin
      chk("data_out", dout_v[v.sel], e.data);
      chk("latency", lat, e.lat);
      chk("busy_at_done", {31'b0, busy_v[v.sel]}, 32'd0);
      last[v.sel] = e.data;
      @(posedge clk); #1;
      chk("done_one_cycle", {31'b0, done_v[v.sel]}, 32'd0);
    end
  endtask

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{0, 32'h12347856, 1'b0, 32'h78563412, 4};
    tbl[1]  = '{0, 32'h12347856, 1'b1, 32'h12345678, 3};
    tbl[2]  = '{0, 32'h40302010, 1'b0, 32'h40302010, 2};
    tbl[3]  = '{0, 32'h05050505, 1'b0, 32'h05050505, 2};
    tbl[4]  = '{0, 32'h10203040, 1'b1, 32'h10203040, 2};
    tbl[5]  = '{0, 32'h807F01FF, 1'b0, 32'hFF807F01, 4};
    tbl[6]  = '{2, 32'h40302010, 1'b0, 32'h40302010, 4};
    tbl[7]  = '{2, 32'h05050505, 1'b0, 32'h05050505, 4};
    tbl[8]  = '{2, 32'h12347856, 1'b0, 32'h78563412, 4};
    tbl[9]  = '{1, 32'h807F01FF, 1'b0, 32'h7F01FF80, 4};
    tbl[10] = '{1, 32'h807F01FF, 1'b1, 32'h80FF017F, 4};
    tbl[11] = '{3, 32'h00000309, 1'b0, 32'h00000903, 2};
    tbl[12] = '{3, 32'h00000309, 1'b1, 32'h00000309, 2};
    tbl[13] = '{3, 32'h00000903, 1'b1, 32'h00000309, 2};
    tbl[14] = '{0, 32'h05050505, 1'b1, 32'h05050505, 2};

    rst = 1'b1; start_v = '0; desc_v = '0; din_v = '0;
    for (int i = 0; i < 4; i++) last[i] = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_data_out", dout_v[0], 32'h0);
    chk("reset_busy", {28'b0, busy_v}, 32'h0);
    chk("reset_done", {28'b0, done_v}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back table: each start lands in the cycle after the previous done.
    for (int i = 0; i < 15; i++) run_vec(tbl[i]);

    // start held and data/desc toggled throughout SORT
    start_v[0] = 1'b1; desc_v[0] = 1'b0; din_v[0] = 32'h12347856;
    sb_q.push_back('{32'h78563412, 4});
    @(posedge clk); #1;
    begin
      exp_t e;
      int   lat;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
        din_v[0]  = $urandom;
        desc_v[0] = ~desc_v[0];
        @(posedge clk); #1;
        if (done_v[0]) begin lat = k; break; end
      end
      start_v[0] = 1'b0;
      e = sb_q.pop_front();
      chk("hold_start_data", dout_v[0], e.data);
      chk("hold_start_latency", lat, e.lat);
      last[0] = e.data;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        chk("hold_start_no_second_done", {30'b0, busy_v[0], done_v[0]}, 32'h0);
      end
      chk("hold_start_data_kept", dout_v[0], last[0]);
    end

    // Reset while cnt == 1
    start_v[0] = 1'b1; desc_v[0] = 1'b0; din_v[0] = 32'h12347856;
    @(posedge clk); #1;                         // E0
    start_v[0] = 1'b0;
    @(posedge clk); #1;                         // phase 0 done, cnt now 1
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, busy_v[0]}, 32'h0);
    chk("rst_mid_done", {31'b0, done_v[0]}, 32'h0);
    chk("rst_mid_data_out", dout_v[0], 32'h0);
    for (int i = 0; i < 4; i++) last[i] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (done_v[0]) seen++;
      end
      chk("rst_mid_no_done", seen, 0);
    end
    run_vec(tbl[0]);
    run_vec(tbl[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
